// File: rtl/fixed_point_arbiter.sv
// Two-port round-robin front end for a shared fixed-point unit.
// Latches the winner, runs issue/wait/respond with a ready watchdog.
module fixed_point_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_operand_1,
    input  logic [2*WIDTH-1:0] req_operand_2,
    input  logic [3:0]         req_operation,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [WIDTH-1:0]   resp_result,
    output logic               resp_error,
    output logic [WIDTH-1:0]   fpu_operand_1,
    output logic [WIDTH-1:0]   fpu_operand_2,
    output logic [1:0]         fpu_operation,
    output logic               fpu_start,
    input  logic [WIDTH-1:0]   fpu_result,
    input  logic               fpu_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Last count value before the watchdog expires.
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic             ptr, ptr_nx;
    logic             grant, grant_nx;
    logic             pick;
    logic [WIDTH-1:0] op1_q, op1_nx;
    logic [WIDTH-1:0] op2_q, op2_nx;
    logic [1:0]       opn_q, opn_nx;
    logic [CNT_W-1:0] wd, wd_nx;
    logic [1:0]       req_ready_nx;
    logic [1:0]       resp_valid_nx;
    logic [WIDTH-1:0] resp_result_nx;
    logic             resp_error_nx;
    logic [WIDTH-1:0] fpu_op1_nx;
    logic [WIDTH-1:0] fpu_op2_nx;
    logic [1:0]       fpu_opn_nx;
    logic             fpu_start_nx;
    logic             busy_nx;

    // Requester that wins if the block is idle this cycle.
    always_comb begin
        pick = (req_valid == 2'b11) ? ptr : req_valid[1];
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_nx       = state;
        ptr_nx         = ptr;
        grant_nx       = grant;
        op1_nx         = op1_q;
        op2_nx         = op2_q;
        opn_nx         = opn_q;
        wd_nx          = wd;
        req_ready_nx   = 2'b00;
        resp_valid_nx  = resp_valid;
        resp_result_nx = resp_result;
        resp_error_nx  = resp_error;
        fpu_op1_nx     = fpu_operand_1;
        fpu_op2_nx     = fpu_operand_2;
        fpu_opn_nx     = fpu_operation;
        fpu_start_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_nx     = pick;
                    req_ready_nx = pick ? 2'b10 : 2'b01;
                    op1_nx       = pick ? req_operand_1[2*WIDTH-1:WIDTH]
                                        : req_operand_1[WIDTH-1:0];
                    op2_nx       = pick ? req_operand_2[2*WIDTH-1:WIDTH]
                                        : req_operand_2[WIDTH-1:0];
                    opn_nx       = pick ? req_operation[3:2]
                                        : req_operation[1:0];
                    state_nx     = ISSUE;
                end
            end
            ISSUE: begin
                fpu_op1_nx   = op1_q;
                fpu_op2_nx   = op2_q;
                fpu_opn_nx   = opn_q;
                fpu_start_nx = 1'b1;
                wd_nx        = '0;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (fpu_ready) begin
                    resp_result_nx = fpu_result;
                    resp_error_nx  = 1'b0;
                    state_nx       = RESP;
                end else if (wd == WD_LAST) begin
                    wd_nx          = wd + CNT_W'(1);
                    resp_result_nx = '0;
                    resp_error_nx  = 1'b1;
                    state_nx       = RESP;
                end else begin
                    wd_nx = wd + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_valid == 2'b00) begin
                    resp_valid_nx = grant ? 2'b10 : 2'b01;
                end else if (resp_ready[grant]) begin
                    resp_valid_nx = 2'b00;
                    ptr_nx        = ~grant;
                    state_nx      = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    // State and output registers; reset discards any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            grant         <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            opn_q         <= '0;
            wd            <= '0;
            req_ready     <= '0;
            resp_valid    <= '0;
            resp_result   <= '0;
            resp_error    <= 1'b0;
            fpu_operand_1 <= '0;
            fpu_operand_2 <= '0;
            fpu_operation <= '0;
            fpu_start     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            ptr           <= ptr_nx;
            grant         <= grant_nx;
            op1_q         <= op1_nx;
            op2_q         <= op2_nx;
            opn_q         <= opn_nx;
            wd            <= wd_nx;
            req_ready     <= req_ready_nx;
            resp_valid    <= resp_valid_nx;
            resp_result   <= resp_result_nx;
            resp_error    <= resp_error_nx;
            fpu_operand_1 <= fpu_op1_nx;
            fpu_operand_2 <= fpu_op2_nx;
            fpu_operation <= fpu_opn_nx;
            fpu_start     <= fpu_start_nx;
            busy          <= busy_nx;
        end
    end

endmodule

// File: tb/tb_fixed_point_arbiter.sv
// Bench for fixed_point_arbiter: transaction scoreboard, a behavioural
// fixed-point unit, directed scenarios and a randomized phase.
module tb_fixed_point_arbiter;

    localparam int W   = 32;
    localparam int TMO = 64;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          lat;
    } req_t;

    logic        clk = 0;
    logic        reset = 1;
    logic [1:0]  req_valid = 0;
    logic [1:0]  req_ready;
    logic [63:0] req_operand_1 = 0;
    logic [63:0] req_operand_2 = 0;
    logic [3:0]  req_operation = 0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 0;
    logic [31:0] resp_result;
    logic        resp_error;
    logic [31:0] fpu_operand_1;
    logic [31:0] fpu_operand_2;
    logic [1:0]  fpu_operation;
    logic        fpu_start;
    logic [31:0] fpu_result;
    logic        fpu_ready = 0;
    logic        busy;

    always #5 clk = ~clk;

    fixed_point_arbiter #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand_1(req_operand_1), .req_operand_2(req_operand_2),
        .req_operation(req_operation),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_error(resp_error),
        .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
        .fpu_operation(fpu_operation), .fpu_start(fpu_start),
        .fpu_result(fpu_result), .fpu_ready(fpu_ready),
        .busy(busy)
    );

    // Q21.10 fixed point: 1.0 = 0x400.
    function automatic logic [31:0] isqrt_fx(logic [31:0] a);
        logic [63:0] x, r, t;
        x = {32'd0, a} << 10;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= x) r = t;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] unit_f(logic [1:0] op, logic [31:0] a,
                                           logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return p[41:10];
            default: return isqrt_fx(a);
        endcase
    endfunction

    assign fpu_result = unit_f(fpu_operation, fpu_operand_1, fpu_operand_2);

    int tests = 0, fails = 0, cyc = 0;
    req_t rq0[$], rq1[$];
    logic act = 0, a_err = 0, a_seen = 0;
    int a_port = 0, a_acc = 0, a_due = 0, a_lat = 0;
    logic [31:0] a_res = 0, a_op1 = 0, a_op2 = 0;
    logic [1:0] a_opn = 0;
    logic idle_edge = 0, hs_next = 0, rr_rand = 0;
    int ptr = 0, hold = 0;
    logic [1:0] vdrv = 0;
    int glog[$], acclog[$], slog[$], rvlog[$], errlog[$];
    logic [31:0] reslog[$];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    function automatic int qi(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] q32(logic [31:0] q[$], int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clr_logs();
        glog.delete(); acclog.delete(); slog.delete();
        rvlog.delete(); errlog.delete(); reslog.delete();
    endtask

    task automatic push(int port, logic [1:0] op, logic [31:0] a,
                        logic [31:0] b, int lat);
        req_t t;
        t.a = a; t.b = b; t.op = op; t.lat = lat;
        if (port == 0) rq0.push_back(t);
        else rq1.push_back(t);
    endtask

    // Compare DUT outputs after the edge just passed with the model.
    task automatic check();
        int g;
        req_t t;
        logic [1:0] expr;
        expr = 2'b00;
        g = 0;
        if (idle_edge && vdrv != 2'b00) begin
            g = (vdrv == 2'b11) ? ptr : (vdrv[1] ? 1 : 0);
            expr = (g == 1) ? 2'b10 : 2'b01;
        end
        chk("req_ready", req_ready, expr);
        if (expr != 2'b00) begin
            if (g == 0) t = rq0.pop_front();
            else t = rq1.pop_front();
            act = 1; a_seen = 0;
            a_port = g; a_acc = cyc; a_lat = t.lat;
            a_op1 = t.a; a_op2 = t.b; a_opn = t.op;
            a_err = (t.lat >= TMO);
            a_res = a_err ? 32'd0 : unit_f(t.op, t.a, t.b);
            a_due = cyc + 3 + ((t.lat < TMO) ? t.lat : TMO - 1);
            glog.push_back(g);
            acclog.push_back(cyc);
        end
        if (hs_next) begin
            chk("hs_resp_valid", resp_valid, 0);
            chk("hs_busy", busy, 0);
            act = 0;
            ptr = 1 - a_port;
            hs_next = 0;
            idle_edge = 1;
        end else begin
            idle_edge = idle_edge && (vdrv == 2'b00);
            if (act) begin
                chk("busy", busy, 1);
                chk("fpu_start", fpu_start, (cyc == a_acc + 1));
                if (fpu_start) slog.push_back(cyc - a_acc);
                if (cyc > a_acc && cyc < a_due) begin
                    chk("fpu_operand_1", fpu_operand_1, a_op1);
                    chk("fpu_operand_2", fpu_operand_2, a_op2);
                    chk("fpu_operation", fpu_operation, a_opn);
                end
                chk("resp_valid", resp_valid,
                    (cyc >= a_due) ? ((a_port == 1) ? 2'b10 : 2'b01) : 2'b00);
                if (cyc >= a_due) begin
                    chk("resp_result", resp_result, a_res);
                    chk("resp_error", resp_error, a_err);
                end
                if (resp_valid != 2'b00 && !a_seen) begin
                    a_seen = 1;
                    rvlog.push_back(cyc - a_acc);
                    reslog.push_back(resp_result);
                    errlog.push_back(int'(resp_error));
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_resp_valid", resp_valid, 0);
                chk("idle_fpu_start", fpu_start, 0);
            end
        end
    endtask

    // Drive requesters, response acceptors and the unit for the next edge.
    task automatic drive();
        logic [1:0] rr;
        req_valid[0] = (rq0.size() > 0);
        req_valid[1] = (rq1.size() > 0);
        if (rq0.size() > 0) begin
            req_operand_1[31:0] = rq0[0].a;
            req_operand_2[31:0] = rq0[0].b;
            req_operation[1:0]  = rq0[0].op;
        end else begin
            req_operand_1[31:0] = $urandom;
            req_operand_2[31:0] = $urandom;
        end
        if (rq1.size() > 0) begin
            req_operand_1[63:32] = rq1[0].a;
            req_operand_2[63:32] = rq1[0].b;
            req_operation[3:2]   = rq1[0].op;
        end else begin
            req_operand_1[63:32] = $urandom;
            req_operand_2[63:32] = $urandom;
        end
        vdrv = req_valid;
        rr = rr_rand ? 2'($urandom_range(0, 3)) : 2'b11;
        if (act && cyc >= a_due && hold > 0) begin
            rr[a_port] = 1'b0;
            rr[1 - a_port] = 1'b1;
            hold--;
        end
        resp_ready = rr;
        hs_next = act && (cyc >= a_due) && rr[a_port];
        fpu_ready = act && (a_lat == 0 || cyc >= a_acc + 1 + a_lat);
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        check();
        drive();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || act) && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles, expected idle",
                     name, n);
        end
    endtask

    initial begin
        int r, lat, n;
        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_error", resp_error, 0);
        chk("rst_resp_result", resp_result, 0);
        chk("rst_fpu_op1", fpu_operand_1, 0);
        chk("rst_fpu_start", fpu_start, 0);
        chk("rst_busy", busy, 0);
        reset = 0;
        idle_edge = 1;
        drive();

        // Single ADD, immediate ready.
        clr_logs();
        push(0, OP_ADD, 32'h600, 32'h800, 0);
        run_idle("t1_add", 50);
        chk("t1_grant", qi(glog, 0), 0);
        chk("t1_start_ofs", qi(slog, 0), 1);
        chk("t1_rv_ofs", qi(rvlog, 0), 3);
        chk("t1_result", q32(reslog, 0), 32'hE00);
        chk("t1_error", qi(errlog, 0), 0);

        // SQRT on port 1, ready 17 cycles after start.
        clr_logs();
        push(1, OP_SQRT, 32'h1000, 32'h0, 17);
        run_idle("t3_sqrt", 80);
        chk("t3_rv_ofs", qi(rvlog, 0), 20);
        chk("t3_result", q32(reslog, 0), 32'h800);
        chk("t3_error", qi(errlog, 0), 0);

        // Fairness with both requesters continuously valid.
        clr_logs();
        for (int i = 0; i < 2; i++) begin
            push(0, OP_MUL, 32'h600, 32'h800, 0);
            push(1, OP_MUL, 32'h600, 32'h800, 0);
        end
        run_idle("t2_fair", 100);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", qi(glog, i), i % 2);
            chk("t2_result", q32(reslog, i), 32'hC00);
        end

        // Watchdog boundary: ready at the last sample wins, then timeouts.
        clr_logs();
        push(0, OP_MUL, 32'h600, 32'h800, TMO - 1);
        push(0, OP_MUL, 32'h600, 32'h800, TMO);
        push(0, OP_ADD, 32'h600, 32'h800, 1000);
        push(0, OP_ADD, 32'h600, 32'h800, 0);
        run_idle("t4_timeout", 400);
        chk("t4_ready_wins_ofs", qi(rvlog, 0), 66);
        chk("t4_ready_wins_res", q32(reslog, 0), 32'hC00);
        chk("t4_ready_wins_err", qi(errlog, 0), 0);
        chk("t4_edge_err", qi(errlog, 1), 1);
        chk("t4_edge_res", q32(reslog, 1), 32'h0);
        chk("t4_never_ofs", qi(rvlog, 2), 66);
        chk("t4_never_err", qi(errlog, 2), 1);
        chk("t4_never_res", q32(reslog, 2), 32'h0);
        chk("t4_next_res", q32(reslog, 3), 32'hE00);
        chk("t4_next_err", qi(errlog, 3), 0);

        // Response back-pressure with the other requester waiting.
        clr_logs();
        push(0, OP_SUB, 32'h1000, 32'h400, 0);
        n = 0;
        while (glog.size() == 0 && n < 20) begin step(); n++; end
        push(1, OP_ADD, 32'h400, 32'h400, 0);
        hold = 10;
        run_idle("t5_backpressure", 100);
        chk("t5_order0", qi(glog, 0), 0);
        chk("t5_order1", qi(glog, 1), 1);
        chk("t5_spacing", qi(acclog, 1) - qi(acclog, 0), 15);
        chk("t5_result0", q32(reslog, 0), 32'hC00);
        chk("t5_result1", q32(reslog, 1), 32'h800);

        // Asynchronous reset during WAIT.
        clr_logs();
        push(1, OP_MUL, 32'h600, 32'h800, 1000);
        n = 0;
        while (!(act && cyc >= a_acc + 10) && n < 30) begin step(); n++; end
        #2 reset = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_fpu_start", fpu_start, 0);
        chk("arst_fpu_op1", fpu_operand_1, 0);
        chk("arst_fpu_op2", fpu_operand_2, 0);
        chk("arst_fpu_opn", fpu_operation, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        act = 0; hs_next = 0; ptr = 0; idle_edge = 0; fpu_ready = 0;
        push(0, OP_MUL, 32'h600, 32'h800, 0);
        push(1, OP_MUL, 32'h600, 32'h800, 0);
        @(negedge clk);
        cyc++;
        chk("arst_hold_busy", busy, 0);
        reset = 0;
        idle_edge = 1;
        clr_logs();
        drive();
        run_idle("t6_after_reset", 100);
        chk("t6_first_grant", qi(glog, 0), 0);
        chk("t6_second_grant", qi(glog, 1), 1);
        chk("t6_responses", rvlog.size(), 2);

        // Randomized traffic.
        rr_rand = 1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 7) lat = r;
                else if (r == 7) lat = TMO - 1;
                else if (r == 8) lat = TMO;
                else lat = $urandom_range(10, 30);
                if ($urandom_range(0, 1) == 0) begin
                    if (rq0.size() < 3)
                        push(0, 2'($urandom_range(0, 3)), $urandom, $urandom, lat);
                end else begin
                    if (rq1.size() < 3)
                        push(1, 2'($urandom_range(0, 3)), $urandom, $urandom, lat);
                end
            end
            step();
        end
        run_idle("rand_drain", 3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
